// File: rtl/wb_sched_if.sv
// rtl/wb_sched_if.sv - write-back scheduler bundle: core write-back, load issue/return, hazard check, regfile port
interface wb_sched_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    logic                       core_wr_en_i;
    logic [4:0]                 core_wr_addr_i;
    logic [XLEN-1:0]            core_wr_data_i;
    logic                       ld_issue_i;
    logic [4:0]                 ld_issue_addr_i;
    logic                       ld_valid_i;
    logic                       ld_ready_o;
    logic [XLEN-1:0]            ld_data_i;
    logic [4:0]                 chk_rs1_addr_i;
    logic [4:0]                 chk_rs2_addr_i;
    logic [4:0]                 chk_rd_addr_i;
    logic                       rd_wr_en_o;
    logic [4:0]                 rd_wr_addr_o;
    logic [XLEN-1:0]            rd_wr_data_o;
    logic                       stall_o;
    logic [$clog2(DEPTH):0]     ld_pend_o;
    logic                       ovf_o;

    modport slave (
        input  core_wr_en_i, core_wr_addr_i, core_wr_data_i,
        input  ld_issue_i, ld_issue_addr_i, ld_valid_i, ld_data_i,
        input  chk_rs1_addr_i, chk_rs2_addr_i, chk_rd_addr_i,
        output ld_ready_o, rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o,
        output stall_o, ld_pend_o, ovf_o
    );

    modport master (
        output core_wr_en_i, core_wr_addr_i, core_wr_data_i,
        output ld_issue_i, ld_issue_addr_i, ld_valid_i, ld_data_i,
        output chk_rs1_addr_i, chk_rs2_addr_i, chk_rd_addr_i,
        input  ld_ready_o, rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o,
        input  stall_o, ld_pend_o, ovf_o
    );
endinterface

// File: rtl/wb_sched.sv
// rtl/wb_sched.sv - shares the regfile write port between core write-back and in-order load returns
module wb_sched #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    wb_sched_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_t;

    hold_t              r_hold_state;
    hold_t              w_hold_next;
    logic [4:0]         r_fifo [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [4:0]         r_hold_addr;
    logic [XLEN-1:0]    r_hold_data;

    logic               w_ready;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_capture;
    logic [4:0]         w_head;
    logic               w_sel;
    logic [4:0]         w_addr;
    logic [XLEN-1:0]    w_data;
    logic               w_hit;
    logic [PW-1:0]      w_off;

    assign w_ready   = (r_hold_state == HOLD_EMPTY);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_head    = r_fifo[r_rd_ptr];
    // A return with nothing outstanding is a protocol error and is dropped.
    assign w_pop     = bus.ld_valid_i && w_ready && (r_count != '0);
    assign w_push    = bus.ld_issue_i && (!w_full || w_pop);
    assign w_capture = w_pop && bus.core_wr_en_i;

    always_comb begin
        w_hold_next = r_hold_state;
        case (r_hold_state)
            HOLD_EMPTY: if (w_capture)          w_hold_next = HOLD_FULL;
            HOLD_FULL:  if (!bus.core_wr_en_i)  w_hold_next = HOLD_EMPTY;
            default:                            w_hold_next = HOLD_EMPTY;
        endcase
    end

    always_comb begin
        w_sel  = 1'b0;
        w_addr = '0;
        w_data = '0;
        if (bus.core_wr_en_i) begin
            w_sel  = 1'b1;
            w_addr = bus.core_wr_addr_i;
            w_data = bus.core_wr_data_i;
        end else if (r_hold_state == HOLD_FULL) begin
            w_sel  = 1'b1;
            w_addr = r_hold_addr;
            w_data = r_hold_data;
        end else if (w_pop) begin
            w_sel  = 1'b1;
            w_addr = w_head;
            w_data = bus.ld_data_i;
        end
    end

    // Pending set: live FIFO slots plus a full hold register; x0 never hazards.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rd_ptr;
            if ((CW'(w_off) < r_count) && (r_fifo[i] != 5'd0) &&
                ((r_fifo[i] == bus.chk_rs1_addr_i) || (r_fifo[i] == bus.chk_rs2_addr_i) ||
                 (r_fifo[i] == bus.chk_rd_addr_i)))
                w_hit = 1'b1;
        end
        if ((r_hold_state == HOLD_FULL) && (r_hold_addr != 5'd0) &&
            ((r_hold_addr == bus.chk_rs1_addr_i) || (r_hold_addr == bus.chk_rs2_addr_i) ||
             (r_hold_addr == bus.chk_rd_addr_i)))
            w_hit = 1'b1;
    end

    assign bus.ld_ready_o   = w_ready;
    assign bus.rd_wr_en_o   = w_sel && (w_addr != 5'd0);
    assign bus.rd_wr_addr_o = w_addr;
    assign bus.rd_wr_data_o = w_data;
    assign bus.stall_o      = w_hit || w_full;
    assign bus.ld_pend_o    = r_count + CW'(r_hold_state == HOLD_FULL);
    assign bus.ovf_o        = bus.ld_issue_i && w_full && !w_pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hold_state <= HOLD_EMPTY;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.ld_issue_addr_i;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count      <= r_count + CW'(w_push) - CW'(w_pop);
            r_hold_state <= w_hold_next;
            if (w_capture) begin
                r_hold_addr <= w_head;
                r_hold_data <= bus.ld_data_i;
            end
        end
    end
endmodule

// File: tb/tb_wb_sched.sv
// tb/tb_wb_sched.sv - directed bench for wb_sched
module tb_wb_sched;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    wb_sched_if #(.XLEN(32), .DEPTH(2)) bus ();

    wb_sched #(.XLEN(32), .DEPTH(2)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.core_wr_en_i    = 1'b0;
        bus.core_wr_addr_i  = '0;
        bus.core_wr_data_i  = '0;
        bus.ld_issue_i      = 1'b0;
        bus.ld_issue_addr_i = '0;
        bus.ld_valid_i      = 1'b0;
        bus.ld_data_i       = '0;
        bus.chk_rs1_addr_i  = '0;
        bus.chk_rs2_addr_i  = '0;
        bus.chk_rd_addr_i   = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a);
        bus.ld_issue_i      = 1'b1;
        bus.ld_issue_addr_i = a;
    endtask

    task automatic ret(input logic [31:0] d);
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();
        rst_n = 1'b0;
        #12;
        chk("rst_wr_en", bus.rd_wr_en_o, 0);
        chk("rst_wr_addr", bus.rd_wr_addr_o, 0);
        chk("rst_wr_data", bus.rd_wr_data_o, 0);
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_pend", bus.ld_pend_o, 0);
        chk("rst_ovf", bus.ovf_o, 0);
        chk("rst_ready", bus.ld_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();

        // load x5, returned two cycles later with the core idle
        issue(5'd5); bus.chk_rs1_addr_i = 5'd5; #1;
        chk("t1_stall_issue", bus.stall_o, 0);
        chk("t1_pend_issue", bus.ld_pend_o, 0);
        nxt(); idle(); bus.chk_rs1_addr_i = 5'd5; #1;
        chk("t1_stall_pend", bus.stall_o, 1);
        chk("t1_pend_pend", bus.ld_pend_o, 1);
        nxt(); ret(32'hDEADBEEF); #1;
        chk("t1_wr_en", bus.rd_wr_en_o, 1);
        chk("t1_wr_addr", bus.rd_wr_addr_o, 5);
        chk("t1_wr_data", bus.rd_wr_data_o, 32'hDEADBEEF);
        chk("t1_stall_ret", bus.stall_o, 1);
        nxt(); idle(); bus.chk_rs1_addr_i = 5'd5; #1;
        chk("t1_stall_after", bus.stall_o, 0);
        chk("t1_pend_after", bus.ld_pend_o, 0);
        chk("t1_wr_en_after", bus.rd_wr_en_o, 0);

        // load x7 collides with a core write to x3
        nxt(); idle(); issue(5'd7);
        nxt(); idle(); #1;
        chk("t2_pend0", bus.ld_pend_o, 1);
        ret(32'h11); bus.core_wr_en_i = 1'b1; bus.core_wr_addr_i = 5'd3; bus.core_wr_data_i = 32'h22; #1;
        chk("t2_core_en", bus.rd_wr_en_o, 1);
        chk("t2_core_addr", bus.rd_wr_addr_o, 3);
        chk("t2_core_data", bus.rd_wr_data_o, 32'h22);
        chk("t2_ready_cap", bus.ld_ready_o, 1);
        nxt(); idle(); bus.chk_rs1_addr_i = 5'd7; #1;
        chk("t2_pend1", bus.ld_pend_o, 1);
        chk("t2_ready_hold", bus.ld_ready_o, 0);
        chk("t2_stall_hold", bus.stall_o, 1);
        chk("t2_drain_en", bus.rd_wr_en_o, 1);
        chk("t2_drain_addr", bus.rd_wr_addr_o, 7);
        chk("t2_drain_data", bus.rd_wr_data_o, 32'h11);
        nxt(); #1;
        chk("t2_pend2", bus.ld_pend_o, 0);
        chk("t2_ready_back", bus.ld_ready_o, 1);
        chk("t2_stall_clear", bus.stall_o, 0);
        chk("t2_idle_en", bus.rd_wr_en_o, 0);

        // fill, overflow, issue with same-cycle return
        nxt(); idle(); issue(5'd1);
        nxt(); idle(); issue(5'd2); #1;
        chk("t3_stall_one", bus.stall_o, 0);
        nxt(); idle(); #1;
        chk("t3_pend_full", bus.ld_pend_o, 2);
        chk("t3_stall_full", bus.stall_o, 1);
        issue(5'd3); #1;
        chk("t3_ovf", bus.ovf_o, 1);
        nxt(); idle(); #1;
        chk("t3_ovf_clear", bus.ovf_o, 0);
        chk("t3_pend_ovf", bus.ld_pend_o, 2);
        issue(5'd4); ret(32'hA1); #1;
        chk("t3_swap_ovf", bus.ovf_o, 0);
        chk("t3_swap_addr", bus.rd_wr_addr_o, 1);
        chk("t3_swap_data", bus.rd_wr_data_o, 32'hA1);
        nxt(); idle(); #1;
        chk("t3_pend_swap", bus.ld_pend_o, 2);
        ret(32'hB2); #1;
        chk("t3_ret2_addr", bus.rd_wr_addr_o, 2);
        chk("t3_ret2_data", bus.rd_wr_data_o, 32'hB2);
        nxt(); idle(); ret(32'hC4); #1;
        chk("t3_ret4_addr", bus.rd_wr_addr_o, 4);
        chk("t3_ret4_data", bus.rd_wr_data_o, 32'hC4);
        nxt(); idle(); bus.chk_rs1_addr_i = 5'd4; #1;
        chk("t3_pend_end", bus.ld_pend_o, 0);
        chk("t3_stall_end", bus.stall_o, 0);

        // pointer wrap: 3 x DEPTH loads returned in order
        for (int k = 0; k < 3; k++) begin
            nxt(); idle(); issue(5'(10 + 2 * k));
            nxt(); idle(); issue(5'(11 + 2 * k));
            nxt(); idle(); ret(32'(100 + k)); #1;
            chk("wrap_addr_a", bus.rd_wr_addr_o, 32'(10 + 2 * k));
            chk("wrap_data_a", bus.rd_wr_data_o, 32'(100 + k));
            nxt(); idle(); ret(32'(200 + k)); #1;
            chk("wrap_addr_b", bus.rd_wr_addr_o, 32'(11 + 2 * k));
            chk("wrap_data_b", bus.rd_wr_data_o, 32'(200 + k));
        end
        nxt(); idle(); #1;
        chk("wrap_pend_end", bus.ld_pend_o, 0);

        // load to x0
        issue(5'd0);
        nxt(); idle(); #1;
        chk("x0_pend", bus.ld_pend_o, 1);
        chk("x0_stall", bus.stall_o, 0);
        ret(32'h5); #1;
        chk("x0_wr_en", bus.rd_wr_en_o, 0);
        chk("x0_ready", bus.ld_ready_o, 1);
        nxt(); idle(); #1;
        chk("x0_pend_after", bus.ld_pend_o, 0);

        // stray return with nothing outstanding
        ret(32'h99); #1;
        chk("stray_wr_en", bus.rd_wr_en_o, 0);
        nxt(); idle(); #1;
        chk("stray_pend", bus.ld_pend_o, 0);
        chk("stray_ready", bus.ld_ready_o, 1);

        // reset with two loads in flight
        issue(5'd8);
        nxt(); idle(); issue(5'd9);
        nxt(); idle(); bus.chk_rs1_addr_i = 5'd8; #1;
        chk("rst2_pend_pre", bus.ld_pend_o, 2);
        rst_n = 1'b0; #1;
        chk("rst2_pend", bus.ld_pend_o, 0);
        chk("rst2_stall", bus.stall_o, 0);
        chk("rst2_ready", bus.ld_ready_o, 1);
        chk("rst2_wr_en", bus.rd_wr_en_o, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        nxt(); idle(); ret(32'h77); #1;
        chk("rst2_ignored_en", bus.rd_wr_en_o, 0);
        nxt(); idle(); #1;
        chk("rst2_pend_after", bus.ld_pend_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_sched.md
# wb_sched

Write-back scheduler for the hxd32 integer register file. It shares the regfile's single write port between the core's single-cycle write-back (ALU result, PC_NEXT) and in-order load returns from a long-latency data-memory port. It tracks destinations of outstanding loads in a small scoreboard FIFO and raises a decode stall on RAW/WAW hazards against them. It sits between the instruction decode/ALU stage, the data-memory response path and the register file write port.

## Interface
- XLEN, 32, data width
- DEPTH, 2, max outstanding loads (power of two, ≥2)

- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- core_wr_en_i  in  1  core write-back request; cannot be back-pressured
- core_wr_addr_i  in  5  core destination register
- core_wr_data_i  in  XLEN  core write data
- ld_issue_i  in  1  load issued this cycle
- ld_issue_addr_i  in  5  load destination register
- ld_valid_i  in  1  load data returning (oldest outstanding load)
- ld_ready_o  out  1  scheduler accepts load data
- ld_data_i  in  XLEN  load return data
- chk_rs1_addr_i, chk_rs2_addr_i, chk_rd_addr_i  in  5 each  registers of the instruction in decode
- rd_wr_en_o  out  1  regfile write enable
- rd_wr_addr_o  out  5  regfile write address
- rd_wr_data_o  out  XLEN  regfile write data
- stall_o  out  1  decode must hold
- ld_pend_o  out  $clog2(DEPTH)+1  outstanding loads (FIFO entries + hold)
- ovf_o  out  1  one-cycle pulse: issue dropped, FIFO full

## Operation
- Address FIFO: DEPTH entries of 5-bit destinations, pointers with wrap-around, count 0..DEPTH. Push on accepted ld_issue_i. Pop on ld_valid_i && ld_ready_o.
- Hold register: states EMPTY/FULL; stores {addr, data}. EMPTY→FULL when a load is accepted while core_wr_en_i=1. FULL→EMPTY when drained, i.e. in a cycle with core_wr_en_i=0.
- ld_ready_o = (hold EMPTY), combinational.
- Write-port priority, combinational: core_wr_en_i, then hold FULL, then accepted load. Core write: rd_wr_* = core inputs. Hold drain: rd_wr_* = hold contents. Accepted load with core idle and hold EMPTY: written same cycle, address = FIFO head.
- x0: any selected write with address 0 drives rd_wr_en_o=0 but is still consumed (FIFO pops, hold drains). Loads to x0 occupy a FIFO slot but never match the hazard compare.
- Hazard compare: pending set = valid FIFO entries plus hold (when FULL), nonzero addresses only.
- stall_o = 1 if chk_rs1/chk_rs2/chk_rd matches any pending address, or FIFO count == DEPTH.
- ld_issue_i while count == DEPTH and no same-cycle pop: issue dropped, ovf_o=1 for that cycle. Push with a same-cycle pop is accepted; count unchanged.
- ld_valid_i while count == 0: protocol error, data ignored, ld_ready_o unaffected.
- ld_pend_o = FIFO count + (hold FULL).

## Timing
- Reset (async assert, sync-release use): FIFO empty, pointers 0, hold EMPTY. Outputs: rd_wr_en_o=0, rd_wr_addr_o=0, rd_wr_data_o=0, stall_o=0, ld_pend_o=0, ovf_o=0, ld_ready_o=1.
- Reset mid-operation discards all outstanding loads and hold data. No write occurs.
- Core write: 0-cycle latency, combinational pass-through.
- Load return, idle port: 0-cycle latency.
- Load return colliding with a core write: written in the first cycle with core_wr_en_i=0. ld_ready_o stays low from the cycle after capture until the drain cycle inclusive.
- Scoreboard update is registered. An issued load makes stall_o visible from the next cycle. An entry clears from the hazard set the cycle after its regfile write.

## Test plan
- Issue load x5, return 0xDEADBEEF two cycles later with core idle -> rd_wr_en_o=1, addr 5, data 0xDEADBEEF that cycle; stall_o on chk_rs1=5 high for the two pending cycles, low after.
- Return load x7=0x11 while core writes x3=0x22 -> x3 written that cycle; hold FULL, ld_ready_o=0; next idle cycle writes x7=0x11; ld_pend_o 1→1→0.
- Issue DEPTH loads -> stall_o=1 on full. Extra issue without a same-cycle return -> ovf_o pulse, ld_pend_o stays DEPTH. Issue plus return in the same cycle -> accepted, count unchanged. Verify pointer wrap over 3×DEPTH loads with returns in order.
- Load to x0 returns 0x5 -> rd_wr_en_o=0, FIFO pops, chk_rs1=0 never stalls.
- Two loads outstanding, assert rst_n_i low mid-flight -> all outputs reset immediately, ld_pend_o=0; subsequent ld_valid_i is ignored.
